// File: rtl/serializer.sv
// Parallel-to-serial Tx stage: shifts 10-bit code groups out MSB-first, fills
// gaps with K28.5 idles, and can substitute a PRBS7 pattern at word boundaries.
//
// state   | meaning
// ST_DATA | shifting encoder words (or idle fill) out of shreg
// ST_PRBS | driving PRBS7 bits from lfsr; words are not accepted
module serializer #(
    parameter logic [9:0] IDLE_WORD = 10'b0011111010,
    parameter logic [6:0] PRBS_SEED = 7'h7F
) (
    input  logic       BitCLK,
    input  logic       Reset,
    input  logic [9:0] TxParallel_10,
    input  logic       TxValid,
    output logic       TxReady,
    input  logic       PrbsEn,
    output logic       TxSerial,
    output logic       WordClk,
    output logic       Underrun
);

    typedef enum logic {
        ST_DATA = 1'b0,
        ST_PRBS = 1'b1
    } modeT;

    modeT       state;
    modeT       stateNext;
    logic [3:0] cnt;
    logic [3:0] cntNext;
    logic [9:0] shreg;
    logic [6:0] lfsr;
    logic [9:0] word;
    logic       atBoundary;
    logic       prbsBit;

    always_comb begin
        stateNext  = state;
        atBoundary = (cnt == 4'd9);
        cntNext    = atBoundary ? 4'd0 : 4'(cnt + 4'd1);
        // The mode may only change where a new word would otherwise start.
        if (atBoundary) begin
            stateNext = PrbsEn ? ST_PRBS : ST_DATA;
        end
        TxReady = Reset & atBoundary & ~PrbsEn;
        word    = TxValid ? TxParallel_10 : IDLE_WORD;
        prbsBit = lfsr[6] ^ lfsr[5];
    end

    always_ff @(posedge BitCLK) begin
        if (!Reset) begin
            state <= ST_DATA;
        end else begin
            state <= stateNext;
        end
    end

    always_ff @(posedge BitCLK) begin
        if (!Reset) begin
            cnt      <= 4'd9;
            shreg    <= '0;
            TxSerial <= 1'b0;
            WordClk  <= 1'b0;
            Underrun <= 1'b0;
            lfsr     <= PRBS_SEED;
        end else begin
            cnt     <= cntNext;
            WordClk <= (cntNext < 4'd5);
            if (stateNext == ST_PRBS) begin
                TxSerial <= prbsBit;
                lfsr     <= {lfsr[5:0], prbsBit};
            end else begin
                // Holding the seed makes every PRBS run start from the same point.
                lfsr <= PRBS_SEED;
                if (atBoundary) begin
                    TxSerial <= word[9];
                    shreg    <= {word[8:0], 1'b0};
                    if (!TxValid) begin
                        Underrun <= 1'b1;
                    end
                end else begin
                    TxSerial <= shreg[9];
                    shreg    <= {shreg[8:0], 1'b0};
                end
            end
        end
    end

endmodule

// File: tb/tb_serializer.sv
// Directed bench for the serializer: data, back-to-back, idle fill, PRBS and reset abort.
module tb_serializer;

    logic       BitCLK = 1'b0;
    logic       Reset;
    logic [9:0] TxParallel_10;
    logic       TxValid;
    logic       TxReady;
    logic       PrbsEn;
    logic       TxSerial;
    logic       WordClk;
    logic       Underrun;

    int nTests = 0;
    int nFail  = 0;

    serializer dut (
        .BitCLK        (BitCLK),
        .Reset         (Reset),
        .TxParallel_10 (TxParallel_10),
        .TxValid       (TxValid),
        .TxReady       (TxReady),
        .PrbsEn        (PrbsEn),
        .TxSerial      (TxSerial),
        .WordClk       (WordClk),
        .Underrun      (Underrun)
    );

    always #5 BitCLK = ~BitCLK;

    task automatic tick();
        @(posedge BitCLK);
        #1;
    endtask

    task automatic test_reset();
        Reset = 1'b0;
        TxValid = 1'b0;
        PrbsEn = 1'b0;
        TxParallel_10 = '0;
        for (int i = 0; i < 3; i++) begin
            tick();
            nTests++;
            if ({TxSerial, WordClk, TxReady, Underrun} !== 4'b0000) begin
                nFail++;
                $display("FAIL reset_outputs cyc=%0d got ser/wclk/rdy/und=%b expected 0000", i,
                         {TxSerial, WordClk, TxReady, Underrun});
            end
        end
        Reset = 1'b1;
        #1;
        nTests++;
        if (TxReady !== 1'b1) begin
            nFail++;
            $display("FAIL reset_release_ready got %b expected 1", TxReady);
        end
    endtask

    task automatic test_single_word();
        logic [9:0] w;
        w = 10'b1010011001;
        TxValid = 1'b1;
        TxParallel_10 = w;
        for (int i = 0; i < 10; i++) begin
            tick();
            nTests++;
            if (TxSerial !== w[9-i]) begin
                nFail++;
                $display("FAIL single_bit i=%0d got %b expected %b", i, TxSerial, w[9-i]);
            end
            nTests++;
            if (TxReady !== (i == 9)) begin
                nFail++;
                $display("FAIL single_ready i=%0d got %b expected %b", i, TxReady, (i == 9));
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [19:0] exp;
        exp = {10'b0110100101, 10'b1001011010};
        TxValid = 1'b1;
        TxParallel_10 = exp[19:10];
        for (int i = 0; i < 20; i++) begin
            tick();
            if (i == 0) TxParallel_10 = exp[9:0];
            nTests++;
            if (TxSerial !== exp[19-i]) begin
                nFail++;
                $display("FAIL b2b_bit i=%0d got %b expected %b", i, TxSerial, exp[19-i]);
            end
            nTests++;
            if (WordClk !== ((i % 10) < 5)) begin
                nFail++;
                $display("FAIL b2b_wordclk i=%0d got %b expected %b", i, WordClk, ((i % 10) < 5));
            end
        end
        nTests++;
        if (Underrun !== 1'b0) begin
            nFail++;
            $display("FAIL b2b_underrun got %b expected 0", Underrun);
        end
    endtask

    task automatic test_underrun();
        logic [19:0] exp;
        exp = {10'b0011111010, 10'b1100110011};
        TxValid = 1'b0;
        TxParallel_10 = 10'b1111111111;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (i == 0) begin
                TxValid = 1'b1;
                TxParallel_10 = exp[9:0];
            end
            nTests++;
            if (TxSerial !== exp[19-i]) begin
                nFail++;
                $display("FAIL underrun_bit i=%0d got %b expected %b", i, TxSerial, exp[19-i]);
            end
            nTests++;
            if (Underrun !== 1'b1) begin
                nFail++;
                $display("FAIL underrun_sticky i=%0d got %b expected 1", i, Underrun);
            end
        end
    endtask

    task automatic test_prbs();
        logic [9:0] w;
        logic [9:0] d;
        logic [9:0] prbs;
        w = 10'b1110001101;
        d = 10'b0100110110;
        prbs = 10'b0000001000;
        TxValid = 1'b1;
        TxParallel_10 = w;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (i == 2) PrbsEn = 1'b1;
            nTests++;
            if (TxSerial !== w[9-i]) begin
                nFail++;
                $display("FAIL prbs_word_completes i=%0d got %b expected %b", i, TxSerial, w[9-i]);
            end
        end
        nTests++;
        if (TxReady !== 1'b0) begin
            nFail++;
            $display("FAIL prbs_entry_ready got %b expected 0", TxReady);
        end
        TxParallel_10 = 10'b1111111111;
        for (int i = 0; i < 10; i++) begin
            tick();
            nTests++;
            if (TxSerial !== prbs[9-i]) begin
                nFail++;
                $display("FAIL prbs_bit i=%0d got %b expected %b", i, TxSerial, prbs[9-i]);
            end
            nTests++;
            if (TxReady !== 1'b0) begin
                nFail++;
                $display("FAIL prbs_ready i=%0d got %b expected 0", i, TxReady);
            end
        end
        PrbsEn = 1'b0;
        TxParallel_10 = d;
        #1;
        nTests++;
        if (TxReady !== 1'b1) begin
            nFail++;
            $display("FAIL prbs_exit_ready got %b expected 1", TxReady);
        end
        for (int i = 0; i < 10; i++) begin
            tick();
            nTests++;
            if (TxSerial !== d[9-i]) begin
                nFail++;
                $display("FAIL prbs_resume_bit i=%0d got %b expected %b", i, TxSerial, d[9-i]);
            end
        end
        PrbsEn = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            nTests++;
            if (TxSerial !== prbs[9-i]) begin
                nFail++;
                $display("FAIL prbs_reentry_bit i=%0d got %b expected %b", i, TxSerial, prbs[9-i]);
            end
        end
        PrbsEn = 1'b0;
    endtask

    task automatic test_reset_midword();
        logic [9:0] r;
        logic [9:0] f;
        r = 10'b1011010110;
        f = 10'b0101101001;
        TxValid = 1'b1;
        TxParallel_10 = r;
        for (int i = 0; i < 5; i++) begin
            tick();
            nTests++;
            if (TxSerial !== r[9-i]) begin
                nFail++;
                $display("FAIL abort_prefix i=%0d got %b expected %b", i, TxSerial, r[9-i]);
            end
        end
        Reset = 1'b0;
        tick();
        nTests++;
        if ({TxSerial, WordClk, TxReady, Underrun} !== 4'b0000) begin
            nFail++;
            $display("FAIL abort_reset got ser/wclk/rdy/und=%b expected 0000",
                     {TxSerial, WordClk, TxReady, Underrun});
        end
        Reset = 1'b1;
        TxParallel_10 = f;
        #1;
        nTests++;
        if (TxReady !== 1'b1) begin
            nFail++;
            $display("FAIL abort_ready got %b expected 1", TxReady);
        end
        for (int i = 0; i < 10; i++) begin
            tick();
            nTests++;
            if (TxSerial !== f[9-i]) begin
                nFail++;
                $display("FAIL abort_fresh_bit i=%0d got %b expected %b", i, TxSerial, f[9-i]);
            end
        end
        nTests++;
        if (Underrun !== 1'b0) begin
            nFail++;
            $display("FAIL abort_underrun got %b expected 0", Underrun);
        end
    endtask

    initial begin
        test_reset();
        test_single_word();
        test_back_to_back();
        test_underrun();
        test_prbs();
        test_reset_midword();
        $display("[TB] %0d tests run, %0d failed", nTests, nFail);
        $finish;
    end

endmodule

// File: doc/serializer.md
Name: serializer

Overview:
- Tx-path parallel-to-serial stage. Sits directly downstream of the 8b/10b encoder and consumes its 10-bit code groups (TxParallel_10).
- Shifts each code group out MSB-first, one bit per bit-clock cycle, with a valid/ready word handshake.
- Inserts K28.5 idle words when no data is offered, and provides a PRBS7 test-pattern mode for link bring-up.

Parameters:
- IDLE_WORD, 10'b0011111010, code group sent on underrun (K28.5 RD-, abcdei fghj order, bit 9 = a).
- PRBS_SEED, 7'h7F, PRBS7 LFSR reset/hold value; must be nonzero.

Ports:
- BitCLK  input  1  bit-rate clock; all state on rising edge.
- Reset  input  1  synchronous, active-low reset.
- TxParallel_10  input  10  code group from encoder; bit 9 transmitted first.
- TxValid  input  1  TxParallel_10 holds a word to send.
- TxReady  output  1  serializer accepts a word at this edge.
- PrbsEn  input  1  select PRBS7 output instead of data; sampled only at word boundary.
- TxSerial  output  1  registered serial bit stream.
- WordClk  output  1  divide-by-10 word-rate clock/strobe, for the encoder's clock domain.
- Underrun  output  1  sticky: an idle word was inserted in data mode.

Behaviour:
- State: bit counter cnt (0..9), 10-bit shift register shreg, PRBS LFSR lfsr[6:0], mode flag prbs_mode, Underrun flag.
- Reset (Reset==0 at edge) sets:
  - cnt=9, shreg=0, TxSerial=0, WordClk=0, Underrun=0, prbs_mode=0, lfsr=PRBS_SEED.
  - TxReady = Reset & (cnt==9) & ~prbs_next, so it is 0 while in reset.
- Reset mid-word aborts the current word immediately; no partial bits follow.
- Counter: cnt increments every edge and wraps 9->0. The edge at which cnt==9 is the word boundary.
- Word boundary, PrbsEn==0:
  - prbs_mode<=0.
  - If TxValid: word=TxParallel_10 (accepted; TxReady is high in that cycle).
  - Else: word=IDLE_WORD and Underrun<=1.
  - Then TxSerial<=word[9] and shreg<={word[8:0],1'b0}.
- Other edges in data mode: TxSerial<=shreg[9] and shreg<=shreg<<1.
- Latency: a word accepted at edge E shows bit 9 on TxSerial in the cycle after E and bit 0 nine cycles later. Back-to-back words have no gap (10 bits per 10 cycles).
- TxReady is combinational from cnt and PrbsEn. It is high exactly one cycle in ten in data mode, and low for all cycles in PRBS mode.
- PRBS mode:
  - Entered or left only at a word boundary: prbs_mode<=PrbsEn.
  - While prbs_mode==1, every edge does TxSerial<=lfsr[6]^lfsr[5] and lfsr<={lfsr[5:0], lfsr[6]^lfsr[5]}.
  - TxValid/TxParallel_10 are ignored, no words are accepted, and Underrun is not set.
  - While prbs_mode==0, lfsr is held at PRBS_SEED, so each PRBS run restarts the sequence.
  - Sequence from seed 7F: 0,0,0,0,0,0,1,...; period 127.
- PrbsEn changes mid-word have no effect until the next boundary.
- WordClk is registered: 1 while cnt in 0..4, 0 while cnt in 5..9. 50% duty.
- Underrun is cleared only by reset.
- TxValid high together with PrbsEn high at a boundary: PRBS wins, the word is not accepted, and TxReady is 0.

Test Plan:
- Reset held 3 cycles, then release -> during reset TxSerial=0, WordClk=0, TxReady=0, Underrun=0; first cycle after release TxReady=1 (cnt=9).
- TxValid=1, TxParallel_10=10'b1010011001 at first boundary -> TxSerial bits 1,0,1,0,0,1,1,0,0,1 on the next 10 cycles; TxReady pulses once per 10 cycles.
- Back-to-back words 10'b0110100101 then 10'b1001011010 -> 20 contiguous bits with no gap; WordClk toggles every 5 cycles.
- TxValid=0 at a boundary -> TxSerial emits 0,0,1,1,1,1,1,0,1,0; Underrun goes to 1 and stays 1 after valid data resumes.
- PrbsEn=1 asserted mid-word -> current word completes unchanged, then TxSerial = 0,0,0,0,0,0,1 for the first 7 PRBS bits; TxReady stays 0; deassert -> data resumes at the next boundary and a re-entry restarts from the seed.
- Reset asserted at bit 4 of a word -> next edge TxSerial=0 and cnt=9; after release a fresh word is accepted on the first cycle and none of the remaining bits of the aborted word appear.
